// File: rtl/cga_mic_pkg.sv
// Shared constants for the CGA/MIC microsequencer blocks: default loop-counter width and
// the save-stack operation encoding.
package cga_mic_pkg;

    localparam int unsigned CGA_MIC_LOOPCNT_W = 4;

    localparam logic [1:0] STK_NONE = 2'd0;
    localparam logic [1:0] STK_PUSH = 2'd1;
    localparam logic [1:0] STK_POP  = 2'd2;
    localparam logic [1:0] STK_XCHG = 2'd3;

    // PUSH together with POP means exchange the count with the stack top.
    function automatic logic [1:0] stk_op_enc(input logic push, input logic pop);
        logic [1:0] op;
        if (push && pop) begin
            op = STK_XCHG;
        end else if (pop) begin
            op = STK_POP;
        end else if (push) begin
            op = STK_PUSH;
        end else begin
            op = STK_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/cga_mic_lifo.sv
// DEPTH x WIDTH register save-stack for nested microcode loops: push, pop and exchange with
// full/empty decode and a sticky misuse flag.
module cga_mic_lifo
    import cga_mic_pkg::*;
#(
    parameter int unsigned WIDTH = CGA_MIC_LOOPCNT_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_top,
    output logic             o_pop_ok,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_err
);

    localparam int unsigned    SPW    = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ONE = SPW'(1);

    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic             r_err;
    logic [SPW-1:0]   w_sp_nxt;
    logic [SPW-1:0]   w_wr_idx;
    logic             w_wr_en;
    logic             w_err_set;

    assign o_empty = (r_sp == '0);
    assign o_full  = (r_sp == SP_MAX);
    assign o_err   = r_err;

    always_comb begin
        w_sp_nxt  = r_sp;
        w_wr_idx  = r_sp;
        w_wr_en   = 1'b0;
        w_err_set = 1'b0;
        o_pop_ok  = 1'b0;
        unique case (i_op)
            STK_PUSH: begin
                if (!o_full) begin
                    w_wr_en  = 1'b1;
                    w_sp_nxt = r_sp + SP_ONE;
                end else begin
                    w_err_set = 1'b1;
                end
            end
            STK_POP: begin
                if (!o_empty) begin
                    o_pop_ok = 1'b1;
                    w_sp_nxt = r_sp - SP_ONE;
                end else begin
                    w_err_set = 1'b1;
                end
            end
            STK_XCHG: begin
                if (!o_empty) begin
                    o_pop_ok = 1'b1;
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_sp - SP_ONE;
                end else begin
                    w_err_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Top read is decoded against sp so an empty stack never exposes uninitialised storage.
    always_comb begin
        o_top = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_sp == SPW'(i + 1)) begin
                o_top = r_stack[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            r_sp <= w_sp_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (i_clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!i_rst && w_wr_en && (w_wr_idx == SPW'(i))) begin
                r_stack[i] <= i_din;
            end
        end
    end

endmodule

// File: rtl/cga_mic_loopcnt.sv
// Microsequencer loop counter: loadable up/down counter with wrap or saturate, terminal-count
// and zero flags, and a save-stack for nested loops.
module cga_mic_loopcnt
    import cga_mic_pkg::*;
#(
    parameter int unsigned WIDTH    = CGA_MIC_LOOPCNT_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SATURATE = 0
) (
    input  logic             i_mclk,
    input  logic             i_mr,
    input  logic [WIDTH-1:0] i_cd,
    input  logic             i_lwcan,
    input  logic             i_ec,
    input  logic             i_up,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clrerr,
    output logic [WIDTH-1:0] o_cswan,
    output logic             o_zero,
    output logic             o_tc,
    output logic             o_sempty,
    output logic             o_sfull,
    output logic             o_serr
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_top;
    logic             w_pop_ok;
    logic             w_at_term;

    cga_mic_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .i_clk     (i_mclk),
        .i_rst     (i_mr),
        .i_op      (stk_op_enc(i_push, i_pop)),
        .i_din     (r_count),
        .i_clr_err (i_clrerr),
        .o_top     (w_top),
        .o_pop_ok  (w_pop_ok),
        .o_empty   (o_sempty),
        .o_full    (o_sfull),
        .o_err     (o_serr)
    );

    assign w_at_term = i_up ? (r_count == '1) : (r_count == '0);

    assign o_cswan = ~r_count;
    assign o_zero  = (r_count == '0);
    assign o_tc    = i_ec & w_at_term;

    // Restore from the stack outranks load, which outranks stepping.
    always_comb begin
        w_count_nxt = r_count;
        if (w_pop_ok) begin
            w_count_nxt = w_top;
        end else if (!i_lwcan) begin
            w_count_nxt = i_cd;
        end else if (i_ec) begin
            if ((SATURATE != 0) && w_at_term) begin
                w_count_nxt = r_count;
            end else if (i_up) begin
                w_count_nxt = r_count + ONE;
            end else begin
                w_count_nxt = r_count - ONE;
            end
        end
    end

    always_ff @(posedge i_mclk) begin
        if (i_mr) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_cga_mic_loopcnt.sv
// Bench for cga_mic_loopcnt: directed scenarios plus randomized traffic against a queue-based
// model of the counter and its save-stack. A saturating instance shares the same stimulus.
module tb_cga_mic_loopcnt;

    logic       clk = 1'b0;
    logic       mr, lwcan, ec, up, push, pop, clrerr;
    logic [3:0] cd;
    logic [3:0] cswan, s_cswan;
    logic       zero, tc, sempty, sfull, serr;
    logic       s_zero, s_tc, s_sempty, s_sfull, s_serr;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] m_count;
    logic       m_err;
    logic [3:0] m_stk [$];

    always #5 clk = ~clk;

    cga_mic_loopcnt #(.WIDTH(4), .DEPTH(4), .SATURATE(0)) dut (
        .i_mclk (clk), .i_mr (mr), .i_cd (cd), .i_lwcan (lwcan), .i_ec (ec), .i_up (up),
        .i_push (push), .i_pop (pop), .i_clrerr (clrerr), .o_cswan (cswan), .o_zero (zero),
        .o_tc (tc), .o_sempty (sempty), .o_sfull (sfull), .o_serr (serr)
    );

    cga_mic_loopcnt #(.WIDTH(4), .DEPTH(4), .SATURATE(1)) dut_sat (
        .i_mclk (clk), .i_mr (mr), .i_cd (cd), .i_lwcan (lwcan), .i_ec (ec), .i_up (up),
        .i_push (push), .i_pop (pop), .i_clrerr (clrerr), .o_cswan (s_cswan), .o_zero (s_zero),
        .o_tc (s_tc), .o_sempty (s_sempty), .o_sfull (s_sfull), .o_serr (s_serr)
    );

    // Drive one cycle of inputs, advance the model across the edge, then sit 1ns past the edge.
    task automatic step(input logic a_mr, input logic [3:0] a_cd, input logic a_lwcan,
                        input logic a_ec, input logic a_up, input logic a_push,
                        input logic a_pop, input logic a_clrerr);
        logic [3:0] nc;
        logic       errset;
        logic       popv;
        mr = a_mr; cd = a_cd; lwcan = a_lwcan; ec = a_ec; up = a_up;
        push = a_push; pop = a_pop; clrerr = a_clrerr;
        @(posedge clk);
        if (a_mr) begin
            m_count = 4'h0;
            m_err   = 1'b0;
            m_stk.delete();
        end else begin
            nc     = m_count;
            errset = 1'b0;
            popv   = a_pop && (m_stk.size() > 0);
            if (a_pop) begin
                if (m_stk.size() > 0) begin
                    nc = m_stk[m_stk.size() - 1];
                    if (a_push) m_stk[m_stk.size() - 1] = m_count;
                    else void'(m_stk.pop_back());
                end else begin
                    errset = 1'b1;
                end
            end else if (a_push) begin
                if (m_stk.size() < 4) m_stk.push_back(m_count);
                else errset = 1'b1;
            end
            if (!popv) begin
                if (!a_lwcan) nc = a_cd;
                else if (a_ec) nc = a_up ? m_count + 4'd1 : m_count - 4'd1;
            end
            m_err   = errset ? 1'b1 : (a_clrerr ? 1'b0 : m_err);
            m_count = nc;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (cswan !== 4'hF) begin n_fail++; $display("FAIL reset_cswan: got %h want F", cswan); end
        n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", zero); end
        n_cmp++; if (sempty !== 1'b1) begin n_fail++; $display("FAIL reset_sempty: got %b want 1", sempty); end
        n_cmp++; if (serr !== 1'b0) begin n_fail++; $display("FAIL reset_serr: got %b want 0", serr); end
        n_cmp++; if (sfull !== 1'b0) begin n_fail++; $display("FAIL reset_sfull: got %b want 0", sfull); end
        n_cmp++; if (s_cswan !== 4'hF) begin n_fail++; $display("FAIL reset_sat_cswan: got %h want F", s_cswan); end
    endtask

    task automatic test_load_count();
        logic [3:0] exp_w [3] = '{4'h1, 4'h0, 4'hF};
        logic [3:0] exp_s [3] = '{4'h1, 4'h0, 4'h0};
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (cswan !== 4'h2) begin n_fail++; $display("FAIL load_cswan: got %h want 2", cswan); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (cswan !== exp_w[i]) begin n_fail++; $display("FAIL up_cswan[%0d]: got %h want %h", i, cswan, exp_w[i]); end
            n_cmp++; if (s_cswan !== exp_s[i]) begin n_fail++; $display("FAIL up_sat_cswan[%0d]: got %h want %h", i, s_cswan, exp_s[i]); end
        end
        n_cmp++; if (s_tc !== 1'b1) begin n_fail++; $display("FAIL up_sat_tc: got %b want 1", s_tc); end
        n_cmp++; if (tc !== 1'b0) begin n_fail++; $display("FAIL up_wrap_tc: got %b want 0", tc); end
        step(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (tc !== 1'b1) begin n_fail++; $display("FAIL up_tc_at_f: got %b want 1", tc); end
    endtask

    task automatic test_down_zero();
        logic [3:0] exp_w [3] = '{4'hE, 4'hF, 4'h0};
        logic [3:0] exp_s [3] = '{4'hE, 4'hF, 4'hF};
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (cswan !== exp_w[i]) begin n_fail++; $display("FAIL down_cswan[%0d]: got %h want %h", i, cswan, exp_w[i]); end
            n_cmp++; if (s_cswan !== exp_s[i]) begin n_fail++; $display("FAIL down_sat_cswan[%0d]: got %h want %h", i, s_cswan, exp_s[i]); end
            if (i == 1) begin
                n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL down_zero: got %b want 1", zero); end
                n_cmp++; if (tc !== 1'b1) begin n_fail++; $display("FAIL down_tc: got %b want 1", tc); end
            end
        end
        n_cmp++; if (s_tc !== 1'b1) begin n_fail++; $display("FAIL down_sat_tc: got %b want 1", s_tc); end
        n_cmp++; if (zero !== 1'b0) begin n_fail++; $display("FAIL down_wrap_zero: got %b want 0", zero); end
    endtask

    task automatic test_nesting();
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (sempty !== 1'b0) begin n_fail++; $display("FAIL nest_sempty_busy: got %b want 0", sempty); end
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (cswan !== 4'h6) begin n_fail++; $display("FAIL nest_pop1: got %h want 6", cswan); end
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (cswan !== 4'hA) begin n_fail++; $display("FAIL nest_pop2: got %h want A", cswan); end
        n_cmp++; if (sempty !== 1'b1) begin n_fail++; $display("FAIL nest_sempty: got %b want 1", sempty); end
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (serr !== 1'b1) begin n_fail++; $display("FAIL nest_underflow_serr: got %b want 1", serr); end
        n_cmp++; if (cswan !== 4'hA) begin n_fail++; $display("FAIL nest_underflow_cswan: got %h want A", cswan); end
    endtask

    task automatic test_overflow_xchg();
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        n_cmp++; if (sfull !== 1'b1) begin n_fail++; $display("FAIL ovf_sfull: got %b want 1", sfull); end
        n_cmp++; if (serr !== 1'b0) begin n_fail++; $display("FAIL ovf_serr_pre: got %b want 0", serr); end
        step(1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (serr !== 1'b1) begin n_fail++; $display("FAIL ovf_serr: got %b want 1", serr); end
        n_cmp++; if (sfull !== 1'b1) begin n_fail++; $display("FAIL ovf_sfull_hold: got %b want 1", sfull); end
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (serr !== 1'b0) begin n_fail++; $display("FAIL ovf_clrerr: got %b want 0", serr); end
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (cswan !== 4'hB) begin n_fail++; $display("FAIL ovf_pop_top: got %h want B", cswan); end
        n_cmp++; if (sfull !== 1'b0) begin n_fail++; $display("FAIL ovf_sfull_clr: got %b want 0", sfull); end
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (cswan !== 4'hD) begin n_fail++; $display("FAIL xchg_cswan: got %h want D", cswan); end
        n_cmp++; if (sempty !== 1'b0) begin n_fail++; $display("FAIL xchg_sp: got sempty %b want 0", sempty); end
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (cswan !== 4'h8) begin n_fail++; $display("FAIL xchg_top: got %h want 8", cswan); end
    endtask

    task automatic test_precedence();
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (cswan !== 4'h5) begin n_fail++; $display("FAIL prec_pop_wins: got %h want 5", cswan); end
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (serr !== 1'b1) begin n_fail++; $display("FAIL prec_set_over_clr: got %b want 1", serr); end
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (cswan !== 4'hF) begin n_fail++; $display("FAIL prec_mr_cswan: got %h want F", cswan); end
        n_cmp++; if (sempty !== 1'b1) begin n_fail++; $display("FAIL prec_mr_sempty: got %b want 1", sempty); end
        n_cmp++; if (serr !== 1'b0) begin n_fail++; $display("FAIL prec_mr_serr: got %b want 0", serr); end
    endtask

    task automatic test_random();
        logic want_tc;
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 4) != 0),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
            want_tc = ec && (up ? (m_count == 4'hF) : (m_count == 4'h0));
            n_cmp++; if (cswan !== ~m_count) begin n_fail++; $display("FAIL rnd_cswan[%0d]: got %h want %h", i, cswan, ~m_count); end
            n_cmp++; if (zero !== (m_count == 4'h0)) begin n_fail++; $display("FAIL rnd_zero[%0d]: got %b want %b", i, zero, m_count == 4'h0); end
            n_cmp++; if (tc !== want_tc) begin n_fail++; $display("FAIL rnd_tc[%0d]: got %b want %b", i, tc, want_tc); end
            n_cmp++; if (sempty !== (m_stk.size() == 0)) begin n_fail++; $display("FAIL rnd_sempty[%0d]: got %b want %b", i, sempty, m_stk.size() == 0); end
            n_cmp++; if (sfull !== (m_stk.size() == 4)) begin n_fail++; $display("FAIL rnd_sfull[%0d]: got %b want %b", i, sfull, m_stk.size() == 4); end
            n_cmp++; if (serr !== m_err) begin n_fail++; $display("FAIL rnd_serr[%0d]: got %b want %b", i, serr, m_err); end
        end
    endtask

    initial begin
        mr = 1'b1; cd = 4'h0; lwcan = 1'b1; ec = 1'b0; up = 1'b0;
        push = 1'b0; pop = 1'b0; clrerr = 1'b0;
        m_count = 4'h0; m_err = 1'b0;
        test_reset();
        test_load_count();
        test_down_zero();
        test_nesting();
        test_overflow_xchg();
        test_precedence();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
